md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Execute-stage multiply/divide unit for the 5-stage MIPS pipeline.
- Consumes the md-class decode (mult, multu, div, divu, mthi, mtlo) for the instruction in E.
- Holds the HI/LO registers and models multi-cycle latency with a busy flag. The hazard unit uses this flag to stall md-class instructions in D.
- Respects exception cancellation: no architectural write occurs for a cancelled instruction.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu.
- DIV_CYCLES, 10, busy duration in cycles for div/divu.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  E-stage instruction is md-class and valid this cycle.
- md_op  input  3  operation code: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6–7 are no-op.
- cancel  input  1  exception/interrupt being taken this cycle; E-stage instruction must not commit.
- rs_val  input  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source).
- rt_val  input  32  forwarded rt operand (divisor / multiplier).
- hi  output  32  architectural HI, read by mfhi.
- lo  output  32  architectural LO, read by mflo.
- busy  output  1  multi-cycle operation in flight.

Behaviour:
- Reset, asynchronous on posedge reset:
  - hi=0, lo=0, busy=0, counter=0, pending result=0.
  - An operation in flight is abandoned.
- Accept condition: acc = start & ~cancel & ~busy.
- Operation start: acc with md_op in 0..3 at edge T0.
  - Latches the result into internal pend_hi/pend_lo (computed combinationally from rs_val/rt_val at T0).
  - Loads counter with MULT_CYCLES or DIV_CYCLES.
  - Sets busy=1.
- States:
  - IDLE (busy=0) -> RUN on operation start.
  - RUN: counter decrements every edge. At the edge where counter==1, hi/lo <= pend_hi/pend_lo, busy <= 0, return to IDLE.
  - busy is high for exactly N cycles after T0. New hi/lo are visible from cycle T0+N.
- During RUN, hi/lo outputs hold their previous values.
- mult: {hi,lo} = signed 64-bit product of rs_val*rt_val.
- multu: {hi,lo} = unsigned 64-bit product.
- div: lo = signed quotient, truncated toward zero; hi = remainder, carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu: unsigned quotient in lo, remainder in hi.
- Divide by zero (rt_val==0):
  - Full DIV_CYCLES busy period still runs.
  - At completion hi/lo keep their pre-operation values (no write).
- mthi/mtlo: on acc, hi (resp. lo) <= rs_val at the same edge. Latency 0, busy unaffected.
- start & busy: ignored entirely, no state change. The hazard unit guarantees this does not occur; the bench flags it as a warning.
- cancel:
  - Suppresses acc for the same cycle: no start, no mthi/mtlo write.
  - Has no effect on an operation already in RUN, which completes and writes normally.
- md_op 6–7 with start: no effect.
- Simultaneous completion edge and new start: impossible, because busy is still 1 on that edge, so the start is ignored. A start on the next cycle is accepted.

Test Plan:
- mult: rs=0xFFFFFFFD (-3), rt=7, start pulse -> busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB. hi/lo unchanged while busy.
- multu: rs=0xFFFFFFFF, rt=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- div: rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu: rs=7, rt=0, with prior hi=0x11, lo=0x22 -> busy 10 cycles, hi=0x11 and lo=0x22 unchanged.
- mtlo rs=0x1234 with cancel=1 -> lo unchanged.
- mtlo rs=0x1234 without cancel -> lo=0x1234 next cycle, busy stays 0.
- mult start with cancel=1 -> busy stays 0.
- div in flight, assert reset at cycle 4 -> busy=0, hi=lo=0 immediately; no later write.

Source files
------------

// File: rtl/md_unit_if.sv
// Execute-stage multiply/divide bundle.
// E-stage decode and operands in, HI/LO and busy flag out.
interface md_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic        cancel;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  modport master (
    output start, md_op, cancel,
    output rs_val, rt_val,
    input  hi, lo, busy
  );

  modport slave (
    input  start, md_op, cancel,
    input  rs_val, rt_val,
    output hi, lo, busy
  );
endinterface

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers.
// Result is computed at accept and held until the busy window expires.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  md_unit_if.slave   io
);
  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic [31:0]     pend_hi_q, pend_hi_d;
  logic [31:0]     pend_lo_q, pend_lo_d;
  logic            pend_wr_q, pend_wr_d;

  logic            acc;
  logic            sgn;
  logic [63:0]     op_a, op_b, prod;
  logic [31:0]     a_mag, b_mag, b_safe;
  logic [31:0]     q_mag, r_mag, quo, rem;

  assign io.hi   = hi_q;
  assign io.lo   = lo_q;
  assign io.busy = (state_q == RUN);

  always_comb begin
    acc  = io.start & ~io.cancel & (state_q == IDLE);
    // ops 0 and 2 are the signed variants
    sgn  = ~io.md_op[0];
    op_a = {{32{sgn & io.rs_val[31]}}, io.rs_val};
    op_b = {{32{sgn & io.rt_val[31]}}, io.rt_val};
    prod = op_a * op_b;
    a_mag = (sgn & io.rs_val[31]) ? -io.rs_val : io.rs_val;
    b_mag = (sgn & io.rt_val[31]) ? -io.rt_val : io.rt_val;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag = a_mag / b_safe;
    r_mag = a_mag % b_safe;
    quo = (sgn & (io.rs_val[31] ^ io.rt_val[31])) ? -q_mag : q_mag;
    rem = (sgn & io.rs_val[31]) ? -r_mag : r_mag;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          unique case (1'b1)
            (io.md_op[2:1] == 2'b00): begin
              state_d   = RUN;
              cnt_d     = CW'(MULT_CYCLES);
              pend_hi_d = prod[63:32];
              pend_lo_d = prod[31:0];
              pend_wr_d = 1'b1;
            end
            (io.md_op[2:1] == 2'b01): begin
              state_d   = RUN;
              cnt_d     = CW'(DIV_CYCLES);
              pend_hi_d = rem;
              pend_lo_d = quo;
              pend_wr_d = (io.rt_val != 32'd0);
            end
            (io.md_op == 3'd4): hi_d = io.rs_val;
            (io.md_op == 3'd5): lo_d = io.rs_val;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit.
// Directed cases plus random traffic against an arithmetic model.
module tb_md_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  md_unit_if bus();

  md_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .io   (bus)
  );

  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          p_wr;
  int          left;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hi = '0; m_lo = '0;
    p_hi = '0; p_lo = '0;
    p_wr = 0;  left = 0;
  endtask

  // One clock edge of architectural behaviour.
  task automatic model_edge();
    longint a, b, q, r;
    logic [63:0] pr;
    logic [2:0]  op;
    op = bus.md_op;
    if (left > 0) begin
      if (bus.start)
        $display("warn: start while busy ignored t=%0t", $time);
      left--;
      if (left == 0 && p_wr) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (bus.start && !bus.cancel) begin
      case (op)
        3'd0, 3'd1: begin
          if (op == 0) begin
            a = longint'(int'(bus.rs_val));
            b = longint'(int'(bus.rt_val));
          end else begin
            a = longint'({32'b0, bus.rs_val});
            b = longint'({32'b0, bus.rt_val});
          end
          pr = 64'(a * b);
          p_hi = pr[63:32];
          p_lo = pr[31:0];
          p_wr = 1;
          left = 5;
        end
        3'd2, 3'd3: begin
          left = 10;
          p_wr = (bus.rt_val != 0);
          if (p_wr) begin
            if (op == 2) begin
              a = longint'(int'(bus.rs_val));
              b = longint'(int'(bus.rt_val));
            end else begin
              a = longint'({32'b0, bus.rs_val});
              b = longint'({32'b0, bus.rt_val});
            end
            q = a / b;
            r = a % b;
            p_lo = q[31:0];
            p_hi = r[31:0];
          end
        end
        3'd4: m_hi = bus.rs_val;
        3'd5: m_lo = bus.rs_val;
        default: ;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    chk("busy", 32'(bus.busy), 32'(left > 0));
    chk("hi", bus.hi, m_hi);
    chk("lo", bus.lo, m_lo);
  endtask

  task automatic drive(logic [2:0] op, logic [31:0] rs,
                       logic [31:0] rt, logic cn);
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.rs_val = rs;
    bus.rt_val = rt;
    bus.cancel = cn;
    step();
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
  endtask

  task automatic wait_idle(string tag, int exp_n);
    int bc = 0;
    while (bus.busy && bc < 30) begin
      bc++;
      step();
    end
    chk(tag, 32'(bc), 32'(exp_n));
  endtask

  initial begin
    bus.start  = 0;
    bus.md_op  = 0;
    bus.cancel = 0;
    bus.rs_val = 0;
    bus.rt_val = 0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);

    drive(3'd0, 32'hFFFFFFFD, 32'd7, 1'b0);
    wait_idle("mult_lat", 5);
    chk("mult_hi", bus.hi, 32'hFFFFFFFF);
    chk("mult_lo", bus.lo, 32'hFFFFFFEB);

    drive(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
    wait_idle("multu_lat", 5);
    chk("multu_hi", bus.hi, 32'h1);
    chk("multu_lo", bus.lo, 32'hFFFFFFFE);

    drive(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_idle("div_lat", 10);
    chk("div_lo", bus.lo, 32'hFFFFFFFD);
    chk("div_hi", bus.hi, 32'hFFFFFFFF);

    drive(3'd4, 32'h11, 32'd0, 1'b0);
    drive(3'd5, 32'h22, 32'd0, 1'b0);
    drive(3'd3, 32'd7, 32'd0, 1'b0);
    wait_idle("divz_lat", 10);
    chk("divz_hi", bus.hi, 32'h11);
    chk("divz_lo", bus.lo, 32'h22);

    drive(3'd5, 32'h1234, 32'd0, 1'b1);
    chk("mtlo_cancel", bus.lo, 32'h22);
    drive(3'd5, 32'h1234, 32'd0, 1'b0);
    chk("mtlo", bus.lo, 32'h1234);
    chk("mtlo_busy", 32'(bus.busy), 32'h0);

    drive(3'd0, 32'd3, 32'd4, 1'b1);
    chk("mult_cancel", 32'(bus.busy), 32'h0);

    drive(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_idle("ovf_lat", 10);
    chk("ovf_lo", bus.lo, 32'h80000000);
    chk("ovf_hi", bus.hi, 32'h0);

    drive(3'd6, 32'h55, 32'h66, 1'b0);
    chk("nop_busy", 32'(bus.busy), 32'h0);
    chk("nop_lo", bus.lo, 32'h80000000);

    drive(3'd1, 32'd6, 32'd7, 1'b0);
    drive(3'd5, 32'hDEAD, 32'd0, 1'b0);
    wait_idle("ign_lat", 4);
    chk("ign_lo", bus.lo, 32'd42);
    drive(3'd0, 32'd2, 32'd3, 1'b0);
    chk("b2b_busy", 32'(bus.busy), 32'h1);
    wait_idle("b2b_lat", 5);

    drive(3'd2, 32'd100, 32'd3, 1'b0);
    repeat (3) step();
    reset = 1'b1;
    #1;
    model_reset();
    chk("arst_busy", 32'(bus.busy), 32'h0);
    chk("arst_hi", bus.hi, 32'h0);
    chk("arst_lo", bus.lo, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (12) step();

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(2) == 0) begin
        logic [31:0] rs, rt;
        rs = $urandom;
        rt = $urandom;
        case ($urandom_range(7))
          0: rt = 0;
          1: begin rs = 32'h80000000; rt = '1; end
          2: rt = $urandom_range(9);
          default: ;
        endcase
        if (left > 0 && $urandom_range(15) != 0)
          step();
        else
          drive(3'($urandom_range(7)), rs, rt,
                ($urandom_range(5) == 0));
      end else begin
        step();
      end
    end
    repeat (12) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
